ttl374_bus_sequencer: RTL

Sequencer for a bank of 74374-style octal registers that share one tri-state data bus. It owns every register's OE_n and CK lines. Read requests are granted round-robin, with a guaranteed bus-turnaround gap, so that at most one register ever drives the bus. Write requests produce single-cycle CK strobes. The block sits between the microcode/control logic and the register bank in the ND-120 datapath.

---
 rtl/ttl374_seq_pkg.sv | 19 +
 rtl/ttl374_bus_sequencer_rr_arbiter.sv | 36 +++
 rtl/ttl374_bus_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ttl374_seq_pkg.sv
// ttl374_seq_pkg
//   Shared definitions for the '374 bus sequencer:
//     seq_state_e - sequencer FSM encoding
//     MAX_NREG    - largest register bank the sequencer supports
//     OE_N_RESET  - idle/reset level of the OE_n lines (nobody drives)
package ttl374_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_TURN  = 2'd2,
        ST_DRIVE = 2'd3
    } seq_state_e;

    localparam int MAX_NREG = 8;

    localparam logic [MAX_NREG-1:0] OE_N_RESET = '1;

endpackage

// File: rtl/ttl374_bus_sequencer_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker for the read requests.
//   Ports:
//     req_i   - request vector, one bit per register
//     ptr_i   - index where the search starts (wraps at NREG)
//     gnt_o   - one-hot grant of the first requester found from ptr_i
//     valid_o - high when any request is present
module rr_arbiter
    import ttl374_seq_pkg::*;
#(
    parameter int NREG = 4
) (
    input  logic [NREG-1:0]         req_i,
    input  logic [$clog2(NREG)-1:0] ptr_i,
    output logic [NREG-1:0]         gnt_o,
    output logic                    valid_o
);

    localparam int PW = $clog2(NREG);

    logic [PW-1:0] idx;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREG; k++) begin
            idx = PW'((int'(ptr_i) + k) % NREG);
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttl374_bus_sequencer.sv
// ttl374_bus_sequencer
//   Owns OE_n and CK of a bank of 74374 registers sharing one tri-state bus.
//   Writes (fixed priority, lowest index) become single-cycle CK strobes;
//   reads are granted round-robin and always pass through a bus-turnaround
//   gap so that at most one register drives the bus at any time.
//   Ports:
//     clock_i    - system clock, rising edge
//     reset_i    - synchronous, active high
//     rd_req_i   - level read requests, held until rd_done_o[i]
//     wr_req_i   - level write requests, held until wr_done_o[i]
//     oe_n_o     - OE_n per register, active low, at most one low
//     ck_o       - CK per register, one-cycle strobe
//     rd_gnt_o   - one-hot, high while register i drives
//     rd_done_o  - pulse in the last drive cycle
//     wr_done_o  - pulse coincident with ck_o
//     busy_o     - high whenever the FSM is not IDLE
//
//   state  | meaning
//   IDLE   | arbitrate; writes beat reads
//   WRITE  | ck/wr_done strobe for one cycle
//   TURN   | all OE_n high for TURN_CYCLES; abort if the read request drops
//   DRIVE  | selected OE_n low for DRIVE_CYCLES, rd_done in the last one
module ttl374_bus_sequencer
    import ttl374_seq_pkg::*;
#(
    parameter int NREG         = 4,
    parameter int TURN_CYCLES  = 1,
    parameter int DRIVE_CYCLES = 2
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic [NREG-1:0] rd_req_i,
    input  logic [NREG-1:0] wr_req_i,
    output logic [NREG-1:0] oe_n_o,
    output logic [NREG-1:0] ck_o,
    output logic [NREG-1:0] rd_gnt_o,
    output logic [NREG-1:0] rd_done_o,
    output logic [NREG-1:0] wr_done_o,
    output logic            busy_o
);

    localparam int PW      = $clog2(NREG);
    localparam int CNT_MAX = (TURN_CYCLES > DRIVE_CYCLES) ? TURN_CYCLES : DRIVE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [NREG-1:0] ONE_HOT0 = NREG'(1);
    localparam logic [NREG-1:0] OE_IDLE  = OE_N_RESET[NREG-1:0];

    seq_state_e      state_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   sel_q;
    logic [NREG-1:0] oe_n_q;
    logic [NREG-1:0] ck_q;
    logic [NREG-1:0] rd_gnt_q;
    logic [NREG-1:0] rd_done_q;
    logic [NREG-1:0] wr_done_q;
    logic            busy_q;

    logic [NREG-1:0] wr_gnt_d;
    logic [NREG-1:0] rd_gnt_d;
    logic            rd_valid_d;
    logic [PW-1:0]   rd_idx_d;
    logic [NREG-1:0] sel_oh_d;
    logic [PW-1:0]   ptr_d;

    // Isolate the lowest set bit: fixed-priority write grant.
    assign wr_gnt_d = wr_req_i & (~wr_req_i + ONE_HOT0);

    rr_arbiter #(
        .NREG (NREG)
    ) u_rr_arbiter (
        .req_i   (rd_req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (rd_gnt_d),
        .valid_o (rd_valid_d)
    );

    always_comb begin
        rd_idx_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rd_gnt_d[i]) begin
                rd_idx_d = PW'(i);
            end
        end
    end

    assign sel_oh_d = ONE_HOT0 << sel_q;
    assign ptr_d    = (sel_q == PW'(NREG - 1)) ? '0 : sel_q + PW'(1);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            sel_q     <= '0;
            oe_n_q    <= OE_IDLE;
            ck_q      <= '0;
            rd_gnt_q  <= '0;
            rd_done_q <= '0;
            wr_done_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            // Strobes default low; each state raises them for exactly one cycle.
            ck_q      <= '0;
            wr_done_q <= '0;
            rd_done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|wr_req_i) begin
                        state_q   <= ST_WRITE;
                        ck_q      <= wr_gnt_d;
                        wr_done_q <= wr_gnt_d;
                        busy_q    <= 1'b1;
                    end else if (rd_valid_d) begin
                        state_q <= ST_TURN;
                        sel_q   <= rd_idx_d;
                        cnt_q   <= CW'(TURN_CYCLES);
                        busy_q  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                ST_TURN: begin
                    if (!rd_req_i[sel_q]) begin
                        // Requester withdrew before the bus was driven.
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CW'(1)) begin
                        state_q  <= ST_DRIVE;
                        cnt_q    <= CW'(DRIVE_CYCLES);
                        oe_n_q   <= ~sel_oh_d;
                        rd_gnt_q <= sel_oh_d;
                        ptr_q    <= ptr_d;
                        if (DRIVE_CYCLES == 1) begin
                            rd_done_q <= sel_oh_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == CW'(1)) begin
                        state_q  <= ST_IDLE;
                        oe_n_q   <= OE_IDLE;
                        rd_gnt_q <= '0;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                        // Next cycle is the last drive cycle.
                        if (cnt_q == CW'(2)) begin
                            rd_done_q <= sel_oh_d;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    oe_n_q   <= OE_IDLE;
                    rd_gnt_q <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign oe_n_o    = oe_n_q;
    assign ck_o      = ck_q;
    assign rd_gnt_o  = rd_gnt_q;
    assign rd_done_o = rd_done_q;
    assign wr_done_o = wr_done_q;
    assign busy_o    = busy_q;

endmodule
